// File: rtl/otfs_ct_pkg.sv
// Shared types and helpers for the OTFS corner-turn feeder.
// Read-FSM states, FFT config word and read-address mapping.
package otfs_ct_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CONFIG,
        RD_STREAM,
        RD_DRAIN
    } rd_state_e;

    localparam logic [6:0] CFG_RSVD = 7'b0;

    function automatic logic [7:0] cfg_word(input logic fwd);
        return {CFG_RSVD, fwd};
    endfunction

    // Transpose walks a column: n (row) is the fast index.
    function automatic logic [31:0] rd_addr(
        input logic [31:0] idx,
        input logic        transpose,
        input int          log2_m,
        input int          log2_n
    );
        logic [31:0] n_mask;
        logic [31:0] m;
        logic [31:0] n;
        n_mask = (32'd1 << log2_n) - 32'd1;
        m      = idx >> log2_n;
        n      = idx & n_mask;
        return transpose ? ((n << log2_m) | m) : idx;
    endfunction

endpackage

// File: rtl/otfs_corner_turn_feeder_ram.sv
// Ping-pong sample store: simple dual-port, registered read.
// Address MSB selects the bank.
module otfs_pingpong_ram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] WrData,
    input  logic          RdEn,
    input  logic [AW-1:0] RdAddr,
    output logic [DW-1:0] RdData
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) mem[WrAddr] <= WrData;
        if (RdEn) RdData <= mem[RdAddr];
    end

endmodule

// File: rtl/otfs_corner_turn_feeder.sv
// OTFS delay-Doppler frame capture with corner-turn readout
// into an AXI-Stream FFT core.
module otfs_corner_turn_feeder
    import otfs_ct_pkg::*;
#(
    parameter int LOG2_M  = 6,
    parameter int LOG2_N  = 6,
    parameter int IN_W    = 16,
    parameter int SHIFT   = 2,
    parameter int OUT_W   = 16,
    parameter bit FFT_FWD = 1'b1
) (
    input  logic               Clk,
    input  logic               Srst,
    input  logic               Start,
    input  logic               ContinuousEn,
    input  logic               TransposeEn,
    input  logic               RecSigDataValid,
    input  logic [IN_W-1:0]    RecSigRe,
    input  logic [IN_W-1:0]    RecSigIm,
    output logic               RecSigReady,
    output logic [7:0]         CfgTdata,
    output logic               CfgTvalid,
    input  logic               CfgTready,
    output logic [2*OUT_W-1:0] FftTdata,
    output logic               FftTvalid,
    input  logic               FftTready,
    output logic               FftTlast,
    output logic               FrameDone,
    output logic               Overflow
);

    localparam int MN_W = LOG2_M + LOG2_N;
    localparam int AW   = MN_W + 1;
    localparam int DW   = 2 * IN_W;
    localparam int OW   = 2 * OUT_W;
    localparam logic [MN_W-1:0] LAST_IDX = '1;

    function automatic logic [OUT_W-1:0] scale(
        input logic [IN_W-1:0] x
    );
        logic signed [IN_W+OUT_W-1:0] w;
        w = (IN_W+OUT_W)'($signed(x));
        return OUT_W'(w >>> SHIFT);
    endfunction

    logic            armed;
    logic            cont_q;
    logic            wr_bank;
    logic [MN_W-1:0] wr_cnt;
    logic            overflow_q;
    logic [1:0]      full_q;
    logic            wr_fire;
    logic            wr_last;

    rd_state_e       state_q;
    rd_state_e       state_d;
    logic            rd_bank;
    logic            tr_q;
    logic [MN_W-1:0] rd_idx;
    logic            issue;
    logic            clr_full;
    logic            cfg_vld;
    logic            rd_vld;
    logic            rd_tl;
    logic            rd_fe;
    logic [AW-1:0]   raddr;
    logic [DW-1:0]   rdata;
    logic            idx_tl;

    logic [OW-1:0]   f_data [2];
    logic            f_tl   [2];
    logic            f_fe   [2];
    logic [1:0]      occ;
    logic            wptr;
    logic            rptr;
    logic            pop;
    logic [2:0]      lvl;
    logic            issue_ok;
    logic            frame_done_q;

    assign RecSigReady = armed & ~full_q[wr_bank];
    assign wr_fire     = RecSigDataValid & RecSigReady;
    assign wr_last     = wr_fire & (wr_cnt == LAST_IDX);

    always_ff @(posedge Clk) begin
        if (Srst) begin
            armed      <= 1'b0;
            cont_q     <= 1'b0;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_fire) wr_cnt <= wr_cnt + MN_W'(1);
            if (wr_last) begin
                wr_bank <= ~wr_bank;
                if (!cont_q) armed <= 1'b0;
            end
            if (RecSigDataValid & armed & ~RecSigReady)
                overflow_q <= 1'b1;
            // A fresh Start re-arms even on a frame's final sample.
            if (Start) begin
                armed      <= 1'b1;
                cont_q     <= ContinuousEn;
                overflow_q <= 1'b0;
            end
        end
    end

    // Write and read sides never touch the same bank in one cycle.
    always_ff @(posedge Clk) begin
        if (Srst) begin
            full_q <= 2'b00;
        end else begin
            if (wr_last)  full_q[wr_bank] <= 1'b1;
            if (clr_full) full_q[rd_bank] <= 1'b0;
        end
    end

    assign pop      = FftTvalid & FftTready;
    assign lvl      = {1'b0, occ} + {2'b0, rd_vld} - {2'b0, pop};
    assign issue_ok = lvl < 3'd2;

    always_comb begin
        state_d  = state_q;
        cfg_vld  = 1'b0;
        issue    = 1'b0;
        clr_full = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank]) state_d = RD_CONFIG;
            end
            RD_CONFIG: begin
                cfg_vld = 1'b1;
                if (CfgTready) state_d = RD_STREAM;
            end
            RD_STREAM: begin
                issue = issue_ok;
                if (issue_ok && rd_idx == LAST_IDX)
                    state_d = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (pop && f_fe[rptr]) begin
                    clr_full = 1'b1;
                    state_d  = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    assign idx_tl = tr_q ? (&rd_idx[LOG2_N-1:0])
                         : (&rd_idx[LOG2_M-1:0]);

    always_ff @(posedge Clk) begin
        if (Srst) begin
            state_q      <= RD_IDLE;
            rd_bank      <= 1'b0;
            tr_q         <= 1'b0;
            rd_idx       <= '0;
            rd_vld       <= 1'b0;
            rd_tl        <= 1'b0;
            rd_fe        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == RD_IDLE && full_q[rd_bank])
                tr_q <= TransposeEn;
            if (issue) rd_idx <= rd_idx + MN_W'(1);
            if (clr_full) rd_bank <= ~rd_bank;
            rd_vld       <= issue;
            rd_tl        <= issue & idx_tl;
            rd_fe        <= issue & (rd_idx == LAST_IDX);
            frame_done_q <= clr_full;
        end
    end

    assign raddr = {rd_bank,
                    MN_W'(rd_addr(32'(rd_idx), tr_q, LOG2_M, LOG2_N))};

    otfs_pingpong_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .Clk    (Clk),
        .WrEn   (wr_fire),
        .WrAddr ({wr_bank, wr_cnt}),
        .WrData ({RecSigIm, RecSigRe}),
        .RdEn   (issue),
        .RdAddr (raddr),
        .RdData (rdata)
    );

    // Skid FIFO: occupancy plus the one in-flight read never exceeds 2.
    always_ff @(posedge Clk) begin
        if (Srst) begin
            occ  <= 2'd0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                f_data[i] <= '0;
                f_tl[i]   <= 1'b0;
                f_fe[i]   <= 1'b0;
            end
        end else begin
            if (rd_vld) begin
                f_data[wptr] <= {scale(rdata[DW-1:IN_W]),
                                 scale(rdata[IN_W-1:0])};
                f_tl[wptr]   <= rd_tl;
                f_fe[wptr]   <= rd_fe;
                wptr         <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            occ <= occ + {1'b0, rd_vld} - {1'b0, pop};
        end
    end

    assign FftTvalid = occ != 2'd0;
    assign FftTdata  = f_data[rptr];
    assign FftTlast  = FftTvalid & f_tl[rptr];
    assign CfgTvalid = cfg_vld;
    assign CfgTdata  = cfg_word(FFT_FWD);
    assign FrameDone = frame_done_q;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_otfs_corner_turn_feeder.sv
// Directed bench for the OTFS corner-turn feeder.
// Scoreboard of expected beats, checked by immediate assertions.
module tb_otfs_corner_turn_feeder;

    localparam int LM = 2;
    localparam int LN = 3;
    localparam int M  = 4;
    localparam int N  = 8;
    localparam int MN = 32;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Srst;
    logic        Start;
    logic        ContinuousEn;
    logic        TransposeEn;
    logic        RecSigDataValid;
    logic [15:0] RecSigRe;
    logic [15:0] RecSigIm;
    logic        RecSigReady;
    logic [7:0]  CfgTdata;
    logic        CfgTvalid;
    logic        CfgTready;
    logic [31:0] FftTdata;
    logic        FftTvalid;
    logic        FftTready = 1'b0;
    logic        FftTlast;
    logic        FrameDone;
    logic        Overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   beat_cnt = 0;
    int   fd_cnt = 0;
    logic cfg_pend = 1'b0;
    logic hold = 1'b0;
    logic [32:0] hold_v;
    logic rdy_rand = 1'b0;
    logic rdy_level = 1'b1;

    otfs_corner_turn_feeder #(
        .LOG2_M(LM), .LOG2_N(LN), .IN_W(16),
        .SHIFT(2), .OUT_W(16), .FFT_FWD(1'b1)
    ) dut (
        .Clk(Clk), .Srst(Srst), .Start(Start),
        .ContinuousEn(ContinuousEn), .TransposeEn(TransposeEn),
        .RecSigDataValid(RecSigDataValid),
        .RecSigRe(RecSigRe), .RecSigIm(RecSigIm),
        .RecSigReady(RecSigReady),
        .CfgTdata(CfgTdata), .CfgTvalid(CfgTvalid),
        .CfgTready(CfgTready),
        .FftTdata(FftTdata), .FftTvalid(FftTvalid),
        .FftTready(FftTready), .FftTlast(FftTlast),
        .FrameDone(FrameDone), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        #1;
        FftTready = rdy_rand ? ($urandom_range(0, 99) < 30) : rdy_level;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Srst) begin
            cfg_pend = 1'b0;
            hold     = 1'b0;
        end else begin
            if (CfgTvalid && CfgTready) begin
                chk("cfg_data", 64'(CfgTdata), 64'(8'h01));
                cfg_pend = 1'b1;
            end
            if (FrameDone) fd_cnt++;
            if (hold) begin
                chk("stall_valid", 64'(FftTvalid), 64'(1));
                chk("stall_data", 64'({FftTlast, FftTdata}), 64'(hold_v));
            end
            hold   = FftTvalid && !FftTready;
            hold_v = {FftTlast, FftTdata};
            if (FftTvalid && FftTready) begin
                beat_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL extra_beat: observed %0h expected none",
                           FftTdata);
                end else begin
                    e = q.pop_front();
                    chk("beat_data", 64'(FftTdata), 64'(e.data));
                    chk("beat_last", 64'(FftTlast), 64'(e.last));
                    if (e.first) begin
                        chk("cfg_first", 64'(cfg_pend), 64'(1));
                        cfg_pend = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push_frame(input int base, input bit tr);
        exp_t e;
        for (int i = 0; i < MN; i++) begin
            int a;
            a = tr ? ((i % N) * M + (i / N)) : i;
            e.first = (i == 0);
            e.last  = tr ? ((i % N) == N - 1) : ((i % M) == M - 1);
            e.data  = {16'(-(base + a)), 16'(base + a)};
            q.push_back(e);
        end
    endtask

    task automatic put(input logic [15:0] re, input logic [15:0] im);
        int n;
        n = 0;
        RecSigDataValid = 1'b1;
        RecSigRe = re;
        RecSigIm = im;
        forever begin
            @(negedge Clk);
            if (RecSigReady) break;
            n++;
            if (n > 3000) begin
                chk("put_timeout", 64'(RecSigReady), 64'(1));
                break;
            end
        end
        @(posedge Clk);
        #1;
        RecSigDataValid = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int k = 0; k < MN; k++)
            put(16'(4 * (base + k)), 16'(-4 * (base + k)));
    endtask

    task automatic start_pulse(input logic cont);
        ContinuousEn = cont;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge Clk);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'(0));
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        int fd0;
        int n;
        Srst = 1'b1;
        Start = 1'b0;
        ContinuousEn = 1'b0;
        TransposeEn = 1'b1;
        RecSigDataValid = 1'b0;
        RecSigRe = '0;
        RecSigIm = '0;
        CfgTready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", 64'(RecSigReady), 64'(0));
        chk("rst_cfgv", 64'(CfgTvalid), 64'(0));
        chk("rst_cfgd", 64'(CfgTdata), 64'(8'h01));
        chk("rst_fftv", 64'(FftTvalid), 64'(0));
        chk("rst_fftd", 64'(FftTdata), 64'(0));
        chk("rst_last", 64'(FftTlast), 64'(0));
        chk("rst_done", 64'(FrameDone), 64'(0));
        chk("rst_ovf", 64'(Overflow), 64'(0));
        Srst = 1'b0;
        @(posedge Clk);
        #1;

        // transpose readout
        fd0 = fd_cnt;
        start_pulse(1'b0);
        chk("armed_ready", 64'(RecSigReady), 64'(1));
        push_frame(0, 1'b1);
        send_frame(0);
        drain(500);
        chk("tr_done", 64'(fd_cnt), 64'(fd0 + 1));

        // bypass readout
        TransposeEn = 1'b0;
        fd0 = fd_cnt;
        start_pulse(1'b0);
        push_frame(0, 1'b0);
        send_frame(0);
        drain(500);
        chk("byp_done", 64'(fd_cnt), 64'(fd0 + 1));

        // random backpressure
        TransposeEn = 1'b1;
        rdy_rand = 1'b1;
        fd0 = fd_cnt;
        start_pulse(1'b0);
        push_frame(0, 1'b1);
        send_frame(0);
        drain(3000);
        rdy_rand = 1'b0;
        chk("bp_done", 64'(fd_cnt), 64'(fd0 + 1));

        // continuous capture with config stall
        CfgTready = 1'b0;
        fd0 = fd_cnt;
        start_pulse(1'b1);
        push_frame(0, 1'b1);
        send_frame(0);
        push_frame(32, 1'b1);
        send_frame(32);
        repeat (2) @(posedge Clk);
        #1;
        chk("both_full_ready", 64'(RecSigReady), 64'(0));
        chk("cfg_stalled", 64'(CfgTvalid), 64'(1));
        chk("ovf_before", 64'(Overflow), 64'(0));
        RecSigDataValid = 1'b1;
        RecSigRe = 16'h7777;
        @(posedge Clk);
        #1;
        RecSigDataValid = 1'b0;
        @(posedge Clk);
        #1;
        chk("ovf_set", 64'(Overflow), 64'(1));
        repeat (100) @(posedge Clk);
        #1;
        chk("still_blocked", 64'(RecSigReady), 64'(0));
        CfgTready = 1'b1;
        n = 0;
        while (fd_cnt == fd0 && n < 500) begin
            @(negedge Clk);
            n++;
        end
        chk("first_drain", 64'(fd_cnt), 64'(fd0 + 1));
        chk("ready_after_drain", 64'(RecSigReady), 64'(1));
        @(posedge Clk);
        #1;
        push_frame(64, 1'b1);
        send_frame(64);
        drain(1000);
        chk("cont_done", 64'(fd_cnt), 64'(fd0 + 3));
        chk("ovf_sticky", 64'(Overflow), 64'(1));

        // sign and shift, bypass order
        Srst = 1'b1;
        @(posedge Clk);
        #1;
        Srst = 1'b0;
        chk("ovf_cleared", 64'(Overflow), 64'(0));
        TransposeEn = 1'b0;
        fd0 = fd_cnt;
        start_pulse(1'b0);
        begin
            exp_t e;
            for (int k = 0; k < MN; k++) begin
                e.first = (k == 0);
                e.last  = (k % M) == M - 1;
                e.data  = {16'(-k), 16'(k)};
                if (k == 0) e.data = {16'h1FFF, 16'hE000};
                if (k == 1) e.data = {16'hFFFF, 16'h0000};
                q.push_back(e);
            end
        end
        put(16'h8000, 16'h7FFF);
        put(16'h0003, 16'hFFFD);
        for (int k = 2; k < MN; k++)
            put(16'(4 * k), 16'(-4 * k));
        drain(500);
        chk("sign_done", 64'(fd_cnt), 64'(fd0 + 1));

        // reset mid-stream at beat 10
        TransposeEn = 1'b1;
        start_pulse(1'b0);
        push_frame(0, 1'b1);
        fd0 = beat_cnt;
        send_frame(0);
        n = 0;
        while (beat_cnt < fd0 + 10 && n < 500) begin
            @(negedge Clk);
            n++;
        end
        chk("reach_beat10", 64'(beat_cnt), 64'(fd0 + 10));
        @(posedge Clk);
        #1;
        Srst = 1'b1;
        q.delete();
        @(posedge Clk);
        #1;
        chk("rst_mid_valid", 64'(FftTvalid), 64'(0));
        chk("rst_mid_ready", 64'(RecSigReady), 64'(0));
        @(posedge Clk);
        #1;
        Srst = 1'b0;
        fd0 = fd_cnt;
        start_pulse(1'b0);
        push_frame(100, 1'b1);
        send_frame(100);
        drain(500);
        chk("post_rst_done", 64'(fd_cnt), 64'(fd0 + 1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
